// File: rtl/bc_debounce.sv
// Byte-wide switch debouncer: every bit is synchronized, then must disagree with
// its debounced output for STABLE consecutive cycles before the output follows.
module bc_debounce #(
  parameter int STABLE = 50000,
  parameter int CNT_W  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] bc_in,
  output logic [7:0] bc_out,
  output logic       chg,
  output logic [7:0] chg_mask
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STABLE - 1);

  logic [7:0] s1_q;
  logic [7:0] s2_q;
  logic [7:0] bc_out_q;
  logic [7:0] bc_out_d;
  logic [7:0] chg_mask_q;
  logic       chg_q;
  logic [7:0] done_d;

  // One independent stability counter per bit; a bit completes on the
  // STABLE-th consecutive cycle of disagreement.
  for (genvar gi = 0; gi < 8; gi++) begin : g_bit
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             differ;
    logic             done;

    assign differ     = s2_q[gi] ^ bc_out_q[gi];
    assign done       = differ && (cnt_q == LIMIT);
    assign done_d[gi] = done;

    always_comb begin
      cnt_d = '0;
      if (differ && !done) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  // A completing bit always disagrees with its output, so toggling it adopts s2.
  assign bc_out_d = bc_out_q ^ done_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      bc_out_q   <= '0;
      chg_mask_q <= '0;
      chg_q      <= 1'b0;
    end else begin
      s1_q       <= bc_in;
      s2_q       <= s1_q;
      bc_out_q   <= bc_out_d;
      chg_mask_q <= done_d;
      chg_q      <= |done_d;
    end
  end

  assign bc_out   = bc_out_q;
  assign chg      = chg_q;
  assign chg_mask = chg_mask_q;

endmodule

// File: tb/tb_bc_debounce.sv
// Bench for bc_debounce (STABLE=4): sliding-window reference model checked every
// cycle, plus hand-computed expectations for the directed scenarios.
module tb_bc_debounce;
  localparam int STABLE = 4;
  localparam int CNT_W  = 3;

  logic       clk;
  logic       rst_n;
  logic [7:0] bc_in;
  logic [7:0] bc_out;
  logic       chg;
  logic [7:0] chg_mask;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  bc_debounce #(.STABLE(STABLE), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bc_in    (bc_in),
    .bc_out   (bc_out),
    .chg      (chg),
    .chg_mask (chg_mask)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the value the filter sees is bc_in two edges late; a bit
  // flips once the last STABLE seen values all disagree with the output.
  logic [7:0] m_d1, m_d2, m_out, m_mask;
  logic       m_chg;
  logic [7:0] hist[$];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_d1 = '0; m_d2 = '0; m_out = '0; m_mask = '0; m_chg = 1'b0;
      hist.delete();
    end else begin
      hist.push_back(m_d2);
      if (hist.size() > STABLE) void'(hist.pop_front());
      m_mask = '0;
      if (hist.size() == STABLE) begin
        for (int b = 0; b < 8; b++) begin
          bit all_diff;
          all_diff = 1'b1;
          for (int j = 0; j < STABLE; j++)
            if (hist[j][b] == m_out[b]) all_diff = 1'b0;
          m_mask[b] = all_diff;
        end
      end
      m_out = m_out ^ m_mask;
      m_chg = |m_mask;
      m_d2  = m_d1;
      m_d1  = bc_in;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_bc_out", bc_out, m_out);
      chk("model_chg", {7'd0, chg}, {7'd0, m_chg});
      chk("model_chg_mask", chg_mask, m_mask);
    end
  end

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bc_in = 8'h00;
    edge_();
    edge_();
    rst_n = 1'b1;
  endtask

  typedef struct { logic [7:0] val; int hold; } vec_t;
  vec_t tbl[12];

  initial begin
    rst_n = 1'b0;
    bc_in = 8'h00;
    do_reset();
    cmp_en = 1;
    chk("reset_bc_out", bc_out, 8'h00);
    chk("reset_chg", {7'd0, chg}, 8'h00);
    chk("reset_chg_mask", chg_mask, 8'h00);

    // A5 applied from edge 0: output updates at edge 5 with a single pulse
    bc_in = 8'hA5;
    for (int e = 0; e <= 8; e++) begin
      edge_();
      if (e <= 4) begin
        chk("a5_hold_out", bc_out, 8'h00);
        chk("a5_hold_chg", {7'd0, chg}, 8'h00);
      end else if (e == 5) begin
        chk("a5_out", bc_out, 8'hA5);
        chk("a5_chg", {7'd0, chg}, 8'h01);
        chk("a5_mask", chg_mask, 8'hA5);
        chk("a5_model_pin", m_out, 8'hA5);
      end else begin
        chk("a5_after_out", bc_out, 8'hA5);
        chk("a5_after_chg", {7'd0, chg}, 8'h00);
        chk("a5_after_mask", chg_mask, 8'h00);
      end
    end
    $display("seq a5_settle: bc_out=%02h", bc_out);

    // three-cycle glitch on bit 0 must be rejected
    bc_in = 8'hA4;
    for (int e = 0; e <= 11; e++) begin
      edge_();
      chk("glitch_out", bc_out, 8'hA5);
      chk("glitch_chg", {7'd0, chg}, 8'h00);
      if (e == 2) bc_in = 8'hA5;
    end
    $display("seq glitch_reject: bc_out=%02h", bc_out);

    // staggered bits give two separate pulses
    do_reset();
    bc_in = 8'h01;
    for (int e = 0; e <= 9; e++) begin
      edge_();
      if (e == 1) bc_in = 8'h81;
      if (e == 5) begin
        chk("stag_chg1", {7'd0, chg}, 8'h01);
        chk("stag_mask1", chg_mask, 8'h01);
        chk("stag_out1", bc_out, 8'h01);
      end else if (e == 7) begin
        chk("stag_chg2", {7'd0, chg}, 8'h01);
        chk("stag_mask2", chg_mask, 8'h80);
        chk("stag_out2", bc_out, 8'h81);
      end else begin
        chk("stag_quiet", {7'd0, chg}, 8'h00);
      end
    end
    chk("stag_final", bc_out, 8'h81);
    $display("seq staggered: bc_out=%02h", bc_out);

    // reset at edge 3 discards partial counts; FF appears at edge 9
    do_reset();
    bc_in = 8'hFF;
    for (int e = 0; e <= 10; e++) begin
      edge_();
      if (e >= 3 && e <= 8) begin
        chk("midrst_out", bc_out, 8'h00);
        chk("midrst_chg", {7'd0, chg}, 8'h00);
      end else if (e == 9) begin
        chk("midrst_out_ff", bc_out, 8'hFF);
        chk("midrst_chg_ff", {7'd0, chg}, 8'h01);
        chk("midrst_mask_ff", chg_mask, 8'hFF);
      end else if (e == 10) begin
        chk("midrst_chg_end", {7'd0, chg}, 8'h00);
      end
      if (e == 2) rst_n = 1'b0;
      if (e == 3) rst_n = 1'b1;
    end
    $display("seq mid_reset: bc_out=%02h", bc_out);

    // all bits fall together, then stay quiet
    bc_in = 8'h00;
    for (int e = 0; e <= 25; e++) begin
      edge_();
      if (e < 5) begin
        chk("fall_hold", bc_out, 8'hFF);
      end else if (e == 5) begin
        chk("fall_out", bc_out, 8'h00);
        chk("fall_mask", chg_mask, 8'hFF);
        chk("fall_chg", {7'd0, chg}, 8'h01);
      end else begin
        chk("fall_idle_chg", {7'd0, chg}, 8'h00);
        chk("fall_idle_out", bc_out, 8'h00);
      end
    end
    $display("seq fall_idle: bc_out=%02h", bc_out);

    // mixed holds around the STABLE boundary, checked by the model only
    tbl[0]  = '{8'h3C, 6};  tbl[1]  = '{8'h3D, 2};  tbl[2]  = '{8'h3C, 5};
    tbl[3]  = '{8'hC3, 9};  tbl[4]  = '{8'h00, 3};  tbl[5]  = '{8'hFF, 1};
    tbl[6]  = '{8'h00, 7};  tbl[7]  = '{8'h5A, 4};  tbl[8]  = '{8'hA5, 3};
    tbl[9]  = '{8'h5A, 12}; tbl[10] = '{8'h0F, 5};  tbl[11] = '{8'hF0, 10};
    for (int k = 0; k < 12; k++) begin
      bc_in = tbl[k].val;
      for (int c = 0; c < tbl[k].hold; c++) edge_();
      $display("table[%0d]: bc_in=%02h hold=%0d bc_out=%02h", k, tbl[k].val, tbl[k].hold, bc_out);
    end
    repeat (8) edge_();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bc_debounce.md
BC_DEBOUNCE -- requirements
Module: bc_debounce

Interface
REQ-001 Parameter: STABLE, default 50000, number of consecutive clock cycles a synchronized input bit must differ from its output before the output follows; legal range 2..65535.
REQ-002 Parameter: CNT_W, default 16, width of each per-bit stability counter; SHALL satisfy 2**CNT_W >= STABLE.
REQ-003 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 Port: bc_in  input  8  raw asynchronous switch/button byte.
REQ-006 Port: bc_out  output  8  debounced byte; feeds the binary-to-BCD converter input bc.
REQ-007 Port: chg  output  1  one-cycle pulse, high in the cycle in which bc_out changes.
REQ-008 Port: chg_mask  output  8  bits of bc_out that changed in that cycle; valid only while chg=1, otherwise 0.

Function
REQ-009 Each bc_in bit SHALL pass through a two-flop synchronizer (s1, s2) before any other use; no other logic SHALL read bc_in.
REQ-010 Each bit i SHALL own an independent CNT_W-bit counter cnt[i]; bits SHALL NOT interact.
REQ-011 Per edge, if s2[i]==bc_out[i]: cnt[i]<=0, bc_out[i] unchanged.
REQ-012 Per edge, if s2[i]!=bc_out[i] and cnt[i]<STABLE-1: cnt[i]<=cnt[i]+1.
REQ-013 Per edge, if s2[i]!=bc_out[i] and cnt[i]==STABLE-1: bc_out[i]<=s2[i], cnt[i]<=0, chg_mask[i]<=1.
REQ-014 cnt[i] SHALL never exceed STABLE-1; no wrap-around.
REQ-015 Latency: bc_in bit stable from edge k onward -> bc_out bit updates at edge k+STABLE+1; no earlier.
REQ-016 Any return of s2[i] to bc_out[i] before the count completes SHALL clear cnt[i]; pulses shorter than STABLE synchronized cycles SHALL never reach bc_out.
REQ-017 chg SHALL be registered and equal to OR of the chg_mask bits set at that edge; chg and chg_mask return to 0 the next edge unless another bit completes.
REQ-018 Several bits completing on the same edge SHALL produce one chg pulse with all those bits set in chg_mask.
REQ-019 bc_out, chg, chg_mask SHALL be driven directly from flops (no combinational path from bc_in).

Reset
REQ-020 With rst_n=0 at a rising edge: s1, s2, bc_out, cnt[0..7], chg, chg_mask SHALL all become 0.
REQ-021 Reset asserted mid-count SHALL discard all partial counts; after release a nonzero input needs the full REQ-015 latency.
REQ-022 After reset release, bc_out=0 and chg=0 until a bit completes filtering; an input already nonzero at release SHALL be filtered like any other change.

Verification (STABLE=4, CNT_W=3)
REQ-023 Reset, then bc_in=8'hA5 from edge 0 -> bc_out=8'h00 through edge 4, bc_out=8'hA5 after edge 5, chg=1 and chg_mask=8'hA5 for exactly that one cycle.
REQ-024 bc_out=8'hA5, bc_in bit0 toggled to 0 for 3 cycles then restored -> bc_out stays 8'hA5, chg stays 0 throughout.
REQ-025 bc_out=8'h00, bc_in=8'h01 at edge 0, then 8'h81 at edge 2 -> chg pulse with chg_mask=8'h01 after edge 5, second chg pulse with chg_mask=8'h80 after edge 7, final bc_out=8'h81.
REQ-026 bc_in=8'hFF from edge 0, rst_n=0 at edge 3 only -> bc_out=8'h00 after edge 3; bc_out=8'hFF first after edge 9 (edge 4 + STABLE+1), single chg with chg_mask=8'hFF.
REQ-027 bc_out=8'hFF, bc_in=8'h00 held -> bc_out=8'h00 after STABLE+2 edges, chg_mask=8'hFF, counters idle at 0 afterwards (check via no further chg for 20 cycles).
